// File: rtl/mem_unit.sv
// Word-addressed main memory behind the datapath MAR/MDR, with a level Read/Write
// request, programmable wait states and a ready/busy handshake.
module mem_unit #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MAR,
  input  logic [31:0] MDR_wdata,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        addr_fault
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t               state, next_state;
  logic [3:0]           wait_cnt;
  logic [ADDR_BITS-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic                 req_write;
  logic                 req_fault;
  logic                 request;

  logic [31:0] mem [0:DEPTH-1];

  assign request = Read | Write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && request && WAIT_STATES > 0)
        wait_cnt <= 4'(WAIT_STATES - 1);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (request) next_state = (WAIT_STATES > 0) ? WAIT : ACCESS;
      WAIT:    if (wait_cnt == '0) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      DONE:    if (!Read && !Write) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state == DONE);
    mem_busy  = (state == WAIT) || (state == ACCESS);
  end

  // Request is latched once in IDLE; MAR/MDR are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && request) begin
      req_addr  <= MAR[ADDR_BITS-1:0];
      req_fault <= |MAR[31:ADDR_BITS];
      req_wdata <= MDR_wdata;
      req_write <= Write & ~Read;
    end
  end

  // Array write is gated by reset so a reset on the ACCESS edge suppresses it.
  always_ff @(posedge clk) begin
    if (reset && state == ACCESS && req_write && !req_fault)
      mem[req_addr] <= req_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_rdata  <= '0;
      addr_fault <= 1'b0;
    end else if (state == ACCESS) begin
      addr_fault <= req_fault;
      if (!req_fault && !req_write)
        mem_rdata <= mem[req_addr];
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: default wait-state instance plus a zero-wait instance.
module tb_mem_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] MAR = '0;
    logic [31:0] MDR_wdata = '0;
    logic        rd_a = 1'b0, wr_a = 1'b0;
    logic        rd_z = 1'b0, wr_z = 1'b0;
    logic [31:0] rdata_a, rdata_z;
    logic        ready_a, ready_z, busy_a, busy_z, fault_a, fault_z;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q_a[$];
    logic [32:0] exp_q_z[$];

    always #5 clk = ~clk;

    mem_unit #(.ADDR_BITS(9), .WAIT_STATES(2), .INIT_FILE("")) u_dut (
        .clk(clk), .reset(reset), .MAR(MAR), .MDR_wdata(MDR_wdata),
        .Read(rd_a), .Write(wr_a), .mem_rdata(rdata_a), .mem_ready(ready_a),
        .mem_busy(busy_a), .addr_fault(fault_a)
    );

    mem_unit #(.ADDR_BITS(9), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .reset(reset), .MAR(MAR), .MDR_wdata(MDR_wdata),
        .Read(rd_z), .Write(wr_z), .mem_rdata(rdata_z), .mem_ready(ready_z),
        .mem_busy(busy_z), .addr_fault(fault_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop expected {fault, rdata} on each rising mem_ready.
    logic rdy_d_a = 1'b0, rdy_d_z = 1'b0;
    always @(negedge clk) begin
        logic [32:0] e;
        if (ready_a && !rdy_d_a) begin
            if (exp_q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready_a: got 1 expected 0");
            end else begin
                e = exp_q_a.pop_front();
                check("rdata_a", rdata_a, e[31:0]);
                check("fault_a", {31'd0, fault_a}, {31'd0, e[32]});
            end
        end
        rdy_d_a = ready_a;
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (ready_z && !rdy_d_z) begin
            if (exp_q_z.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready_z: got 1 expected 0");
            end else begin
                e = exp_q_z.pop_front();
                check("rdata_z", rdata_z, e[31:0]);
                check("fault_z", {31'd0, fault_z}, {31'd0, e[32]});
            end
        end
        rdy_d_z = ready_z;
    end

    // One complete transaction; exp_lat counts edges including the sampling edge.
    task automatic access(input bit z, input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rd, input bit exp_f,
                          input int exp_lat, input int hold, input bit change_mid);
        int n = 0;
        int busy_cnt = 0;
        bit got = 0;
        @(negedge clk);
        MAR = addr;
        MDR_wdata = data;
        if (z) begin rd_z = rd; wr_z = wr; exp_q_z.push_back({exp_f, exp_rd}); end
        else   begin rd_a = rd; wr_a = wr; exp_q_a.push_back({exp_f, exp_rd}); end
        while (n < 50 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (change_mid && n == 1) begin
                MAR = 32'h20;
                MDR_wdata = 32'hFFFF_FFFF;
            end
            busy_cnt += int'(z ? busy_z : busy_a);
            got = z ? ready_z : ready_a;
        end
        check("latency", n, exp_lat);
        if (z) check("busy_cycles_z", busy_cnt, 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_ready", {31'd0, ready_a}, 32'd1);
            check("hold_not_busy", {31'd0, busy_a}, 32'd0);
        end
        if (z) begin rd_z = 0; wr_z = 0; end
        else   begin rd_a = 0; wr_a = 0; end
        @(posedge clk);
        @(negedge clk);
        check("ready_drop", {31'd0, z ? ready_z : ready_a}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_ready", {31'd0, ready_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_fault", {31'd0, fault_a}, 32'd0);
        reset = 1'b1;

        access(0, 0, 1, 32'h10,  32'hDEAD_BEEF, 32'h0,         0, 4, 0, 0);
        access(0, 1, 0, 32'h10,  32'h0,         32'hDEAD_BEEF, 0, 4, 0, 0);
        access(0, 0, 1, 32'h000, 32'hCAFE_0001, 32'hDEAD_BEEF, 0, 4, 0, 0);
        access(0, 1, 0, 32'h200, 32'h0,         32'hDEAD_BEEF, 1, 4, 0, 0);
        access(0, 0, 1, 32'h200, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1, 4, 0, 0);
        access(0, 1, 0, 32'h000, 32'h0,         32'hCAFE_0001, 0, 4, 0, 0);
        access(0, 0, 1, 32'h20,  32'h2020_2020, 32'hCAFE_0001, 0, 4, 0, 0);
        // Read+Write together is a read; MAR/MDR changed mid-wait are ignored.
        access(0, 1, 1, 32'h10,  32'h1234_5678, 32'hDEAD_BEEF, 0, 4, 0, 1);
        access(0, 1, 0, 32'h10,  32'h0,         32'hDEAD_BEEF, 0, 4, 5, 0);
        access(0, 0, 1, 32'h30,  32'h1111_2222, 32'hDEAD_BEEF, 0, 4, 0, 0);

        // Write aborted by reset during WAIT.
        @(negedge clk);
        MAR = 32'h30;
        MDR_wdata = 32'hA5A5_A5A5;
        wr_a = 1;
        @(posedge clk);
        @(negedge clk);
        check("mid_busy", {31'd0, busy_a}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_rdata", rdata_a, 32'd0);
        check("mid_rst_ready", {31'd0, ready_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("mid_rst_fault", {31'd0, fault_a}, 32'd0);
        wr_a = 0;
        reset = 1'b1;
        access(0, 1, 0, 32'h30, 32'h0, 32'h1111_2222, 0, 4, 0, 0);

        // Zero-wait instance.
        access(1, 0, 1, 32'h5, 32'h0000_0055, 32'h0,         0, 2, 0, 0);
        access(1, 1, 0, 32'h5, 32'h0,         32'h0000_0055, 0, 2, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("queue_a_empty", exp_q_a.size(), 32'd0);
        check("queue_z_empty", exp_q_z.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
